// File: rtl/controle_multiciclo_pkg.sv
// Shared constants for the multicycle controller: opcodes, ULA ops, mux selects,
// state encoding and the single-bit control flag bundle.
package controle_pkg;

   localparam int unsigned OP_ADDI = 8;
   localparam int unsigned OP_LW   = 9;
   localparam int unsigned OP_SW   = 10;
   localparam int unsigned OP_BEQ  = 11;
   localparam int unsigned OP_BNE  = 12;
   localparam int unsigned OP_JUMP = 13;
   localparam int unsigned OP_NOP  = 14;
   localparam int unsigned OP_HALT = 15;

   localparam int unsigned ULA_ADD = 0;
   localparam int unsigned ULA_SUB = 1;

   localparam int unsigned ULA_B_REG = 0;
   localparam int unsigned ULA_B_UM  = 1;
   localparam int unsigned ULA_B_IMM = 2;

   localparam int unsigned FONTE_ULA   = 0;
   localparam int unsigned FONTE_SAIDA = 1;
   localparam int unsigned FONTE_SALTO = 2;

   typedef enum logic [3:0] {
      INICIO, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I,
      ENDER, MEM_RD, WB_MEM, MEM_WR, DESVIO, SALTO, HALT
   } estado_t;

   typedef struct packed {
      logic esc_cp;
      logic esc_cond_cp;
      logic cond_ne;
      logic ula_a;
      logic esc_ir;
      logic le_mem;
      logic esc_mem;
      logic i_ou_d;
      logic esc_reg;
      logic reg_dst;
      logic mem_para_reg;
      logic halted;
   } ctrl_flags_t;

endpackage

// File: rtl/controle_multiciclo_if.sv
// Controller <-> datapath bundle: IR opcode in, every write enable and mux select out.
interface controle_multiciclo_if #(
   parameter int unsigned OPCODE_W   = 4,
   parameter int unsigned ULA_OP_W   = 4,
   parameter int unsigned ULA_B_W    = 2,
   parameter int unsigned FONTE_CP_W = 2
);
   logic [OPCODE_W-1:0]   opcode;
   logic                  esc_cp;
   logic                  esc_cond_cp;
   logic                  cond_ne;
   logic [FONTE_CP_W-1:0] fonte_cp;
   logic                  ula_a;
   logic [ULA_B_W-1:0]    ula_b;
   logic [ULA_OP_W-1:0]   ula_op;
   logic                  esc_ir;
   logic                  le_mem;
   logic                  esc_mem;
   logic                  i_ou_d;
   logic                  esc_reg;
   logic                  reg_dst;
   logic                  mem_para_reg;
   logic                  halted;

   modport master (
      input  opcode,
      output esc_cp, esc_cond_cp, cond_ne, fonte_cp, ula_a, ula_b, ula_op,
             esc_ir, le_mem, esc_mem, i_ou_d, esc_reg, reg_dst, mem_para_reg, halted
   );

   modport slave (
      output opcode,
      input  esc_cp, esc_cond_cp, cond_ne, fonte_cp, ula_a, ula_b, ula_op,
             esc_ir, le_mem, esc_mem, i_ou_d, esc_reg, reg_dst, mem_para_reg, halted
   );
endinterface

// File: rtl/controle_multiciclo_decod.sv
// Moore output decoder: (state, latched opcode) -> control word.
// mem_pronta only gates the FETCH IR/PC writes; it is tied high when memory never stalls.
module controle_decod
   import controle_pkg::*;
#(
   parameter int unsigned OPCODE_W   = 4,
   parameter int unsigned ULA_OP_W   = 4,
   parameter int unsigned ULA_B_W    = 2,
   parameter int unsigned FONTE_CP_W = 2
) (
   input  estado_t               estado,
   input  logic [OPCODE_W-1:0]   opcode_q,
   input  logic                  mem_pronta,
   output ctrl_flags_t           flags,
   output logic [FONTE_CP_W-1:0] fonte_cp,
   output logic [ULA_B_W-1:0]    ula_b,
   output logic [ULA_OP_W-1:0]   ula_op
);

   always_comb begin
      flags    = '0;
      fonte_cp = '0;
      ula_b    = '0;
      ula_op   = '0;
      case (estado)
         FETCH: begin
            flags.le_mem = 1'b1;
            flags.esc_ir = mem_pronta;
            flags.esc_cp = mem_pronta;
            ula_b        = ULA_B_W'(ULA_B_UM);
            ula_op       = ULA_OP_W'(ULA_ADD);
            fonte_cp     = FONTE_CP_W'(FONTE_ULA);
         end
         // Branch target precomputed into ULASaida while the opcode is decoded
         DECODE: begin
            ula_b  = ULA_B_W'(ULA_B_IMM);
            ula_op = ULA_OP_W'(ULA_ADD);
         end
         EXEC_R: begin
            flags.ula_a = 1'b1;
            ula_b       = ULA_B_W'(ULA_B_REG);
            ula_op      = opcode_q[ULA_OP_W-1:0];
         end
         WB_R: begin
            flags.esc_reg = 1'b1;
            flags.reg_dst = 1'b1;
         end
         EXEC_I, ENDER: begin
            flags.ula_a = 1'b1;
            ula_b       = ULA_B_W'(ULA_B_IMM);
            ula_op      = ULA_OP_W'(ULA_ADD);
         end
         WB_I: flags.esc_reg = 1'b1;
         MEM_RD: begin
            flags.le_mem = 1'b1;
            flags.i_ou_d = 1'b1;
         end
         WB_MEM: begin
            flags.esc_reg      = 1'b1;
            flags.mem_para_reg = 1'b1;
         end
         MEM_WR: begin
            flags.esc_mem = 1'b1;
            flags.i_ou_d  = 1'b1;
         end
         DESVIO: begin
            flags.ula_a       = 1'b1;
            flags.esc_cond_cp = 1'b1;
            flags.cond_ne     = (opcode_q == OPCODE_W'(OP_BNE));
            ula_b             = ULA_B_W'(ULA_B_REG);
            ula_op            = ULA_OP_W'(ULA_SUB);
            fonte_cp          = FONTE_CP_W'(FONTE_SAIDA);
         end
         SALTO: begin
            flags.esc_cp = 1'b1;
            fonte_cp     = FONTE_CP_W'(FONTE_SALTO);
         end
         HALT:    flags.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle CPU control FSM: state register, opcode latch and next-state logic.
// Optional CTRL_MEM_WAIT_EN adds mem_pronta and stalls FETCH/MEM_RD/MEM_WR until memory is ready.
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int unsigned OPCODE_W   = 4,
   parameter int unsigned ULA_OP_W   = 4,
   parameter int unsigned ULA_B_W    = 2,
   parameter int unsigned FONTE_CP_W = 2
) (
   input  logic clk,
   input  logic rst_n,
`ifdef CTRL_MEM_WAIT_EN
   input  logic mem_pronta,
`endif
   controle_multiciclo_if.master bus
);

   estado_t             state_q, state_d;
   logic [OPCODE_W-1:0] opcode_q, opcode_d;
   logic                mem_rdy_c;
   ctrl_flags_t         flags;

`ifdef CTRL_MEM_WAIT_EN
   assign mem_rdy_c = mem_pronta;
`else
   assign mem_rdy_c = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INICIO;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         INICIO: state_d = FETCH;
         FETCH:  if (mem_rdy_c) state_d = DECODE;
         DECODE: begin
            opcode_d = bus.opcode;
            if (bus.opcode < OPCODE_W'(OP_ADDI)) begin
               state_d = EXEC_R;
            end else begin
               case (bus.opcode)
                  OPCODE_W'(OP_ADDI): state_d = EXEC_I;
                  OPCODE_W'(OP_LW),
                  OPCODE_W'(OP_SW):   state_d = ENDER;
                  OPCODE_W'(OP_BEQ),
                  OPCODE_W'(OP_BNE):  state_d = DESVIO;
                  OPCODE_W'(OP_JUMP): state_d = SALTO;
                  OPCODE_W'(OP_HALT): state_d = HALT;
                  default:            state_d = FETCH;
               endcase
            end
         end
         EXEC_R: state_d = WB_R;
         WB_R:   state_d = FETCH;
         EXEC_I: state_d = WB_I;
         WB_I:   state_d = FETCH;
         ENDER:  state_d = (opcode_q == OPCODE_W'(OP_SW)) ? MEM_WR : MEM_RD;
         MEM_RD: if (mem_rdy_c) state_d = WB_MEM;
         WB_MEM: state_d = FETCH;
         MEM_WR: if (mem_rdy_c) state_d = FETCH;
         DESVIO: state_d = FETCH;
         SALTO:  state_d = FETCH;
         HALT:   state_d = HALT;
         default: state_d = INICIO;
      endcase
   end

   controle_decod #(
      .OPCODE_W   (OPCODE_W),
      .ULA_OP_W   (ULA_OP_W),
      .ULA_B_W    (ULA_B_W),
      .FONTE_CP_W (FONTE_CP_W)
   ) u_decod (
      .estado     (state_q),
      .opcode_q   (opcode_q),
      .mem_pronta (mem_rdy_c),
      .flags      (flags),
      .fonte_cp   (bus.fonte_cp),
      .ula_b      (bus.ula_b),
      .ula_op     (bus.ula_op)
   );

   assign bus.esc_cp       = flags.esc_cp;
   assign bus.esc_cond_cp  = flags.esc_cond_cp;
   assign bus.cond_ne      = flags.cond_ne;
   assign bus.ula_a        = flags.ula_a;
   assign bus.esc_ir       = flags.esc_ir;
   assign bus.le_mem       = flags.le_mem;
   assign bus.esc_mem      = flags.esc_mem;
   assign bus.i_ou_d       = flags.i_ou_d;
   assign bus.esc_reg      = flags.esc_reg;
   assign bus.reg_dst      = flags.reg_dst;
   assign bus.mem_para_reg = flags.mem_para_reg;
   assign bus.halted       = flags.halted;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: stimulus queues the expected control word
// for each cycle, a negedge monitor pops and compares against the DUT.
module tb_controle_multiciclo;

   logic clk = 1'b0;
   logic rst_n;
`ifdef CTRL_MEM_WAIT_EN
   logic mem_pronta;
`endif

   controle_multiciclo_if bus ();

   controle_multiciclo dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef CTRL_MEM_WAIT_EN
      .mem_pronta (mem_pronta),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q[$];
   string       name_q[$];

   // Field order: esc_cp esc_cond_cp cond_ne fonte_cp ula_a ula_b ula_op
   //              esc_ir le_mem esc_mem i_ou_d esc_reg reg_dst mem_para_reg halted
   function automatic logic [19:0] mk(input logic ecp, input logic ecc, input logic cne,
                                      input logic [1:0] fcp, input logic ua,
                                      input logic [1:0] ub, input logic [3:0] uop,
                                      input logic eir, input logic lm, input logic em,
                                      input logic iod, input logic er, input logic rd,
                                      input logic mpr, input logic h);
      return {ecp, ecc, cne, fcp, ua, ub, uop, eir, lm, em, iod, er, rd, mpr, h};
   endfunction

   function automatic logic [19:0] dut_word();
      return {bus.esc_cp, bus.esc_cond_cp, bus.cond_ne, bus.fonte_cp, bus.ula_a, bus.ula_b,
              bus.ula_op, bus.esc_ir, bus.le_mem, bus.esc_mem, bus.i_ou_d, bus.esc_reg,
              bus.reg_dst, bus.mem_para_reg, bus.halted};
   endfunction

   localparam logic [19:0] E_INICIO = 20'h0;
   localparam logic [19:0] E_FETCH  = mk(1,0,0,2'b00,0,2'b01,4'h0,1,1,0,0,0,0,0,0);
   localparam logic [19:0] E_FWAIT  = mk(0,0,0,2'b00,0,2'b01,4'h0,0,1,0,0,0,0,0,0);
   localparam logic [19:0] E_DECODE = mk(0,0,0,2'b00,0,2'b10,4'h0,0,0,0,0,0,0,0,0);
   localparam logic [19:0] E_WB_R   = mk(0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,1,0,0);
   localparam logic [19:0] E_EXEC_I = mk(0,0,0,2'b00,1,2'b10,4'h0,0,0,0,0,0,0,0,0);
   localparam logic [19:0] E_WB_I   = mk(0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,0,0,0);
   localparam logic [19:0] E_MEM_RD = mk(0,0,0,2'b00,0,2'b00,4'h0,0,1,0,1,0,0,0,0);
   localparam logic [19:0] E_WB_MEM = mk(0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,1,0,1,0);
   localparam logic [19:0] E_MEM_WR = mk(0,0,0,2'b00,0,2'b00,4'h0,0,0,1,1,0,0,0,0);
   localparam logic [19:0] E_BEQ    = mk(0,1,0,2'b01,1,2'b00,4'h1,0,0,0,0,0,0,0,0);
   localparam logic [19:0] E_BNE    = mk(0,1,1,2'b01,1,2'b00,4'h1,0,0,0,0,0,0,0,0);
   localparam logic [19:0] E_SALTO  = mk(1,0,0,2'b10,0,2'b00,4'h0,0,0,0,0,0,0,0,0);
   localparam logic [19:0] E_HALT   = mk(0,0,0,2'b00,0,2'b00,4'h0,0,0,0,0,0,0,0,1);

   function automatic logic [19:0] e_exec_r(input logic [3:0] op);
      return mk(0,0,0,2'b00,1,2'b00,op,0,0,0,0,0,0,0,0);
   endfunction

   // Monitor: one expected word per cycle, compared mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            logic [19:0] e, g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = dut_word();
            checks++;
            if (g !== e) begin
               errors++;
               $display("FAIL %s: got %05h expected %05h", n, g, e);
            end
            checks++;
            if ((bus.esc_cp && bus.esc_cond_cp) || (bus.le_mem && bus.esc_mem)) begin
               errors++;
               $display("FAIL %s exclusive strobes: got %05h expected no overlap", n, g);
            end
         end
      end
   end

   task automatic push(input logic [19:0] e, input string n);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic step(input logic [19:0] e, input string n);
      @(posedge clk);
      #1;
      push(e, n);
   endtask

   // Full instruction from FETCH; opcode is scrambled after DECODE so later states must use opcode_q
   task automatic instr(input logic [3:0] op, input string n);
      logic [19:0] body[$];
      @(posedge clk);
      #1;
      bus.opcode = op;
      push(E_FETCH, {n, " fetch"});
      step(E_DECODE, {n, " decode"});
      case (op)
         4'h8:    body = '{E_EXEC_I, E_WB_I};
         4'h9:    body = '{E_EXEC_I, E_MEM_RD, E_WB_MEM};
         4'hA:    body = '{E_EXEC_I, E_MEM_WR};
         4'hB:    body = '{E_BEQ};
         4'hC:    body = '{E_BNE};
         4'hD:    body = '{E_SALTO};
         4'hE:    body = '{};
         4'hF:    body = '{};
         default: body = '{e_exec_r(op), E_WB_R};
      endcase
      foreach (body[i]) begin
         @(posedge clk);
         #1;
         bus.opcode = ~op;
         push(body[i], $sformatf("%s body%0d", n, i));
      end
   endtask

   task automatic pulse_reset(input string n);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      push(E_INICIO, n);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      bus.opcode = '0;
`ifdef CTRL_MEM_WAIT_EN
      mem_pronta = 1'b1;
`endif
      step(E_INICIO, "reset held");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push(E_INICIO, "inicio after release");

      instr(4'h3, "R3");
      instr(4'h0, "R0");
      instr(4'h7, "R7");
      instr(4'h8, "ADDI");
      instr(4'h9, "LW");
      instr(4'hA, "SW");
      instr(4'hB, "BEQ");
      instr(4'hC, "BNE");
      instr(4'hD, "JUMP");
      instr(4'hE, "NOP");

      // Reset mid-EXEC_R
      @(posedge clk);
      #1;
      bus.opcode = 4'h5;
      push(E_FETCH, "R5 fetch");
      step(E_DECODE, "R5 decode");
      step(e_exec_r(4'h5), "R5 exec");
      pulse_reset("reset mid exec_r");
      step(E_FETCH, "fetch after reset");
      step(E_DECODE, "decode after reset");
      bus.opcode = 4'h2;
      step(e_exec_r(4'h2), "R2 exec");
      step(E_WB_R, "R2 wb");

`ifdef CTRL_MEM_WAIT_EN
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         mem_pronta = 1'b0;
         bus.opcode = 4'hE;
         push(E_FWAIT, $sformatf("fetch wait%0d", i));
      end
      @(posedge clk);
      #1;
      mem_pronta = 1'b1;
      push(E_FETCH, "fetch ready");
      step(E_DECODE, "decode after wait");
`endif

      instr(4'hF, "HALT");
      for (int i = 0; i < 100; i++) step(E_HALT, $sformatf("halt%0d", i));
      pulse_reset("reset from halt");
      instr(4'h8, "ADDI after halt");

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
